fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage: owns the program counter, issues requests to the instruction memory over a req/gnt/rvalid handshake, and presents the fetched instruction with its PC to the IF/ID pipeline register. It sits directly upstream of IF/ID. It honours the hazard unit's `stall`, and it takes control-flow redirects from EX. At most one memory request is outstanding at any time.

## Interface
- `RESET_PC`, default 64'h0: PC fetched first after reset.
- `NOP_INST`, default 32'h00000013: instruction driven when no valid instruction is held (addi x0,x0,0).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  hazard-unit stall, shared with IF/ID; output is not consumed while high.
- `redirect`  in  1  branch/jump taken in EX; highest priority.
- `redirect_pc`  in  64  target PC; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  64  request address, equal to the internal PC.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid; at least 1 cycle after gnt.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  `if_inst`/`if_pc` hold a real instruction.
- `if_inst`  out  32  instruction to IF/ID.
- `if_pc`  out  64  PC of `if_inst`.

## Operation
- Registers: `pc`, `state`, `if_valid`, `if_inst`, `if_pc`. `imem_req` = (state==FETCH); `imem_addr` = `pc`.
- States:
  - FETCH: `imem_req`=1.
    - `imem_gnt` → WAIT.
    - `redirect` with no gnt → `pc`<=`redirect_pc`, stay FETCH.
    - `redirect` with gnt in the same cycle → `pc`<=`redirect_pc`, go to DRAIN. The old-address request was accepted.
  - WAIT:
    - `imem_rvalid` with no redirect → `if_inst`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1, `pc`<=`pc`+4, go to HOLD.
    - `redirect` → `pc`<=`redirect_pc`. If `imem_rvalid` is also high that cycle, discard the data and go to FETCH; otherwise go to DRAIN.
  - DRAIN: wait for `imem_rvalid`, discard the data, then go to FETCH. A `redirect` here updates `pc` and stays in DRAIN.
  - HOLD:
    - `redirect` → `if_valid`<=0, `if_inst`<=NOP_INST, `pc`<=`redirect_pc`, go to FETCH.
    - Otherwise, `stall`=0 → the output is consumed at this edge: `if_valid`<=0, `if_inst`<=NOP_INST, go to FETCH.
    - Otherwise, `stall`=1 → hold all outputs unchanged.
- Outside HOLD, `if_valid`=0 and `if_inst`=NOP_INST. IF/ID therefore captures bubbles while a fetch is pending.
- PC arithmetic: 64-bit, +4 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- `imem_addr` stays stable while `imem_req`=1 without `imem_gnt`, except on `redirect`.
- Redirect vs stall in the same cycle: redirect wins.
- Squashing a wrong-path instruction already latched in IF/ID is the hazard unit's job, not this block's.

## Timing
- Reset (async):
  - `pc`=RESET_PC, state=FETCH, `if_valid`=0, `if_inst`=NOP_INST, `if_pc`=0.
  - `imem_req` is combinationally 0 while `reset` is high and goes to 1 in the first cycle after deassert.
  - Reset mid-transaction abandons it. The memory must tolerate a dropped rvalid.
- Best case, zero-wait memory:
  - Cycle 0: FETCH with gnt.
  - Cycle 1: WAIT with rvalid.
  - Cycle 2: HOLD, `if_valid`=1; consumed at the end of the cycle if `stall`=0.
  - Cycle 3: FETCH for the next PC.
  - Throughput: one instruction per 3 cycles plus memory wait states.
- Redirect latency: the target address appears on `imem_addr` the cycle after `redirect`, or after the pending `rvalid` when in DRAIN.
- `imem_rvalid` seen in FETCH or HOLD is a protocol error and is ignored.

## Test plan
- Reset with RESET_PC=64'h1000, zero-wait memory, `stall`=0 → addresses 1000, 1004, 1008 in order. `if_valid` pulses every 3rd cycle with the matching `if_pc` and `if_inst`.
- Output in HOLD, `stall`=1 for 4 cycles → `if_inst`/`if_pc`/`if_valid` unchanged and no new `imem_req`. Drop `stall` → consumed, next fetch at PC+4.
- `redirect` to 64'h2002 in WAIT with rvalid 2 cycles later → data discarded (DRAIN), next `imem_addr`=64'h2000, `if_valid` never asserted for the old word.
- `redirect` in HOLD with `stall`=1 → `if_valid` 0 next cycle, `if_inst`=00000013, next request at the redirect target.
- `imem_gnt` held low for 5 cycles → `imem_req` high and `imem_addr` stable throughout. A redirect in cycle 3 changes the address the next cycle.
- `pc`=64'hFFFF_FFFF_FFFF_FFFC fetched → next `imem_addr`=0. Assert `reset` during WAIT → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
// -----------------------------------------------------------------------------
// Instruction fetch stage. This block owns the program counter. It issues one
// instruction-memory request at a time over a req/gnt/rvalid handshake and
// hands the fetched word, together with its PC, to the IF/ID register.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   stall             hazard stall shared with IF/ID; the held output is not
//                     consumed while this is high
//   redirect          taken branch/jump from EX (highest priority)
//   redirect_pc       redirect target; bits [1:0] are forced to zero
//   imem_req          request valid (combinational from state)
//   imem_addr         request address (always the internal pc)
//   imem_gnt          request accepted this cycle
//   imem_rvalid       response valid (arrives at least one cycle after gnt)
//   imem_rdata        response instruction word
//   if_valid          if_inst/if_pc hold a real instruction
//   if_inst           instruction to IF/ID (NOP_INST when not valid)
//   if_pc             PC of the most recently captured instruction
//
// Flow: FETCH (req) -> WAIT (gnt seen) -> HOLD (rvalid seen, output valid)
//       -> FETCH once consumed.
// DRAIN absorbs the single response that is still in flight when a redirect
// arrives after the old request was already granted. This keeps the rule of
// at most one outstanding request, and it stops a wrong-path word from ever
// reaching the output.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] tgt_pc;
  logic [63:0] pc_inc;

  // Targets are always word aligned. The low bits from EX are dropped, not
  // trapped on.
  assign tgt_pc = {redirect_pc[63:2], 2'b00};

  // Plain 64-bit add. Carry-out is discarded, so ...FFFC wraps to 0.
  assign pc_inc = pc + 64'd4;

  // State is forced to FETCH during reset, so the request is qualified with
  // reset. That keeps the bus quiet while reset is held. The address is
  // simply the pc, so it stays stable across un-granted cycles unless a
  // redirect rewrites the pc.
  assign imem_req  = (state == FETCH) && !reset;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_inst  <= NOP_INST;
      if_pc    <= 64'h0;
    end else begin
      case (state)
        FETCH: begin
          // rvalid here has no request behind it and is ignored.
          if (redirect) begin
            pc <= tgt_pc;
            // A grant in the same cycle means the old address is now owed a
            // response. That response must be drained and thrown away.
            state <= imem_gnt ? DRAIN : FETCH;
          end else if (imem_gnt) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (redirect) begin
            pc    <= tgt_pc;
            state <= imem_rvalid ? FETCH : DRAIN;
          end else if (imem_rvalid) begin
            if_inst  <= imem_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc_inc;
            state    <= HOLD;
          end
        end

        DRAIN: begin
          // Later redirects only retarget. The pending response must still
          // come back before a new request goes out.
          if (redirect) pc <= tgt_pc;
          if (imem_rvalid) state <= FETCH;
        end

        HOLD: begin
          // if_pc is left as is on exit. if_valid marks whether it means
          // anything.
          if (redirect) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            pc       <= tgt_pc;
            state    <= FETCH;
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            state    <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (RESET_PC = 64'h1000).
// Each table row holds the inputs applied during one clock cycle and the
// outputs expected during that same cycle, before the edge.
module tb_fetch_stage;

  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NV  = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect, imem_gnt, imem_rvalid;
  logic [63:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic        imem_req, if_valid;
  logic [63:0] imem_addr, if_pc;
  logic [31:0] if_inst;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
  } vec_t;

  vec_t v [NV];

  function automatic vec_t mk(input logic s, input logic r, input logic [63:0] rp,
                              input logic g, input logic rv, input logic [31:0] rd,
                              input logic eq, input logic [63:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [63:0] ep);
    vec_t x;
    x.stall = s; x.redir = r; x.rpc = rp; x.gnt = g; x.rv = rv; x.rdata = rd;
    x.e_req = eq; x.e_addr = ea; x.e_valid = ev; x.e_inst = ei; x.e_pc = ep;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic eq, input logic [63:0] ea,
                         input logic ev, input logic [31:0] ei, input logic [63:0] ep);
    chk({tag, ".imem_req"},  {63'd0, imem_req}, {63'd0, eq});
    chk({tag, ".imem_addr"}, imem_addr, ea);
    chk({tag, ".if_valid"},  {63'd0, if_valid}, {63'd0, ev});
    chk({tag, ".if_inst"},   {32'd0, if_inst},  {32'd0, ei});
    chk({tag, ".if_pc"},     if_pc, ep);
  endtask

  task automatic drive(input vec_t x);
    stall = x.stall; redirect = x.redir; redirect_pc = x.rpc;
    imem_gnt = x.gnt; imem_rvalid = x.rv; imem_rdata = x.rdata;
  endtask

  initial begin
    logic [63:0] top;
    top = 64'hFFFF_FFFF_FFFF_FFFC;
    //          stall redir rpc                    gnt rv rdata          req addr        vld inst           if_pc
    v[0]  = mk(0, 0, 64'h0,                 1, 0, 32'h0,         1, RPC,        0, NOP,           64'h0);
    v[1]  = mk(0, 0, 64'h0,                 0, 1, 32'hA0A0_0000, 0, RPC,        0, NOP,           64'h0);
    v[2]  = mk(0, 0, 64'h0,                 0, 0, 32'h0,         0, 64'h1004,   1, 32'hA0A0_0000, 64'h1000);
    v[3]  = mk(0, 0, 64'h0,                 1, 1, 32'hBAD0_BAD0, 1, 64'h1004,   0, NOP,           64'h1000);
    v[4]  = mk(0, 0, 64'h0,                 0, 1, 32'hA1A1_1111, 0, 64'h1004,   0, NOP,           64'h1000);
    v[5]  = mk(1, 0, 64'h0,                 0, 0, 32'h0,         0, 64'h1008,   1, 32'hA1A1_1111, 64'h1004);
    v[6]  = mk(1, 0, 64'h0,                 0, 0, 32'h0,         0, 64'h1008,   1, 32'hA1A1_1111, 64'h1004);
    v[7]  = mk(1, 0, 64'h0,                 0, 0, 32'h0,         0, 64'h1008,   1, 32'hA1A1_1111, 64'h1004);
    v[8]  = mk(1, 0, 64'h0,                 0, 0, 32'h0,         0, 64'h1008,   1, 32'hA1A1_1111, 64'h1004);
    v[9]  = mk(0, 0, 64'h0,                 0, 1, 32'hBAD1_BAD1, 0, 64'h1008,   1, 32'hA1A1_1111, 64'h1004);
    v[10] = mk(0, 0, 64'h0,                 1, 0, 32'h0,         1, 64'h1008,   0, NOP,           64'h1004);
    v[11] = mk(0, 1, 64'h2002,              0, 0, 32'h0,         0, 64'h1008,   0, NOP,           64'h1004);
    v[12] = mk(0, 0, 64'h0,                 0, 0, 32'h0,         0, 64'h2000,   0, NOP,           64'h1004);
    v[13] = mk(0, 0, 64'h0,                 0, 1, 32'hDEAD_0001, 0, 64'h2000,   0, NOP,           64'h1004);
    v[14] = mk(0, 0, 64'h0,                 1, 0, 32'h0,         1, 64'h2000,   0, NOP,           64'h1004);
    v[15] = mk(0, 0, 64'h0,                 0, 1, 32'hA2A2_2222, 0, 64'h2000,   0, NOP,           64'h1004);
    v[16] = mk(1, 1, 64'h3000,              0, 0, 32'h0,         0, 64'h2004,   1, 32'hA2A2_2222, 64'h2000);
    v[17] = mk(0, 0, 64'h0,                 0, 0, 32'h0,         1, 64'h3000,   0, NOP,           64'h2000);
    v[18] = mk(0, 0, 64'h0,                 0, 0, 32'h0,         1, 64'h3000,   0, NOP,           64'h2000);
    v[19] = mk(0, 1, 64'h4000,              0, 0, 32'h0,         1, 64'h3000,   0, NOP,           64'h2000);
    v[20] = mk(0, 0, 64'h0,                 0, 0, 32'h0,         1, 64'h4000,   0, NOP,           64'h2000);
    v[21] = mk(0, 0, 64'h0,                 0, 0, 32'h0,         1, 64'h4000,   0, NOP,           64'h2000);
    v[22] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 32'h0,       1, 64'h4000,   0, NOP,           64'h2000);
    v[23] = mk(0, 0, 64'h0,                 0, 1, 32'hDEAD_0002, 0, top,        0, NOP,           64'h2000);
    v[24] = mk(0, 0, 64'h0,                 1, 0, 32'h0,         1, top,        0, NOP,           64'h2000);
    v[25] = mk(0, 0, 64'h0,                 0, 1, 32'hA3A3_3333, 0, top,        0, NOP,           64'h2000);
    v[26] = mk(0, 0, 64'h0,                 0, 0, 32'h0,         0, 64'h0,      1, 32'hA3A3_3333, top);
    v[27] = mk(0, 0, 64'h0,                 1, 1, 32'hBAD2_BAD2, 1, 64'h0,      0, NOP,           top);
    v[28] = mk(0, 1, 64'h5000,              0, 1, 32'hBAD3_BAD3, 0, 64'h0,      0, NOP,           top);
    v[29] = mk(0, 0, 64'h0,                 1, 0, 32'h0,         1, 64'h5000,   0, NOP,           top);
    v[30] = mk(0, 0, 64'h0,                 0, 0, 32'h0,         0, 64'h5000,   0, NOP,           top);

    // Reset state while reset is held.
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    #1 chk_out("reset", 1'b0, RPC, 1'b0, NOP, 64'h0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NV; i++) begin
      chk_out($sformatf("row%0d", i), v[i].e_req, v[i].e_addr, v[i].e_valid,
              v[i].e_inst, v[i].e_pc);
      drive(v[i]);
      @(negedge clk);
      #1;
    end

    // DUT now sits in WAIT for 5000. An async reset must clear the outputs
    // without waiting for an edge.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    #1 chk_out("wait_reset", 1'b0, RPC, 1'b0, NOP, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_out("post_reset", 1'b1, RPC, 1'b0, NOP, 64'h0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #1 chk_out("post_reset_wait", 1'b0, RPC, 1'b0, NOP, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
